// File: rtl/instr_decode_stage.sv
// ID pipeline stage: IF/ID register, 32x32 register file with WB bypass, branch/jump/eret/interrupt
// resolution, load-use and branch-operand hazard detection, and next-PC control back to IF.
module instr_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] IR_NON   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_ir,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_npc,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_wa,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_wa,
    input  logic        intr_req,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic [31:0] rs_val,
    output logic [31:0] rt_val,
    output logic [31:0] imm_ext,
    output logic [31:0] npc_ext,
    output logic [31:0] connect,
    output logic [2:0]  mux_pc,
    output logic [1:0]  if_cond,
    output logic [31:0] epc_out,
    output logic        epc_we
);

    localparam logic [2:0] PcBranch = 3'd0;
    localparam logic [2:0] PcJr     = 3'd1;
    localparam logic [2:0] PcIntr   = 3'd2;
    localparam logic [2:0] PcEret   = 3'd3;
    localparam logic [2:0] PcJump   = 3'd4;
    localparam logic [2:0] PcSeq    = 3'd5;

    localparam logic [1:0] CondFlow  = 2'b00;
    localparam logic [1:0] CondStall = 2'b01;
    localparam logic [1:0] CondZero  = 2'b10;

    localparam logic [31:0] EretWord = 32'h4200_0018;

    // StSquash doubles as "ID holds a bubble": entered on reset, redirect and interrupt.
    typedef enum logic [1:0] {StRun, StStall, StSquash} state_e;

    state_e      state_q;
    logic [31:0] ir_q, pc_q, npc_q;
    logic [31:0] regs_q [32];

    logic        full;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        is_beq, is_bne, is_j, is_jal, is_jr, is_eret;
    logic        rs_used, rt_used, br_rs, br_rt;
    logic        load_use, br_hazard, intr_take, stall, taken, redirect;

    assign full  = (state_q != StSquash);
    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign imm   = ir_q[15:0];
    assign funct = ir_q[5:0];

    assign is_beq  = full && (op == 6'h04);
    assign is_bne  = full && (op == 6'h05);
    assign is_j    = full && (op == 6'h02);
    assign is_jal  = full && (op == 6'h03);
    assign is_jr   = full && (op == 6'h00) && (funct == 6'h08);
    assign is_eret = full && (ir_q == EretWord);

    // j/jal/lui/cop0 carry no rs operand; rt is a source only for R-type, branches and stores.
    assign rs_used = full && !(op inside {6'h02, 6'h03, 6'h0F, 6'h10});
    assign rt_used = full && (op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B});
    assign br_rs   = is_beq || is_bne || is_jr;
    assign br_rt   = is_beq || is_bne;

    always_comb begin
        rs_val = regs_q[rs];
        if (rs == 5'd0) begin
            rs_val = '0;
        end else if (wb_we && (wb_addr == rs)) begin
            rs_val = wb_data;
        end
        rt_val = regs_q[rt];
        if (rt == 5'd0) begin
            rt_val = '0;
        end else if (wb_we && (wb_addr == rt)) begin
            rt_val = wb_data;
        end
    end

    assign load_use = ex_mem_read && (ex_wa != 5'd0)
                      && ((rs_used && (ex_wa == rs)) || (rt_used && (ex_wa == rt)));
    // Branch/jr compare in ID, so EX and MEM results are not yet visible to them.
    assign br_hazard = (ex_reg_write && (ex_wa != 5'd0)
                        && ((br_rs && (ex_wa == rs)) || (br_rt && (ex_wa == rt))))
                    || (mem_reg_write && (mem_wa != 5'd0)
                        && ((br_rs && (mem_wa == rs)) || (br_rt && (mem_wa == rt))));

    // A bubble has nothing to restart, so interrupts wait for a real instruction.
    assign intr_take = full && intr_req;
    assign stall     = (load_use || br_hazard) && !intr_take;
    assign taken     = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val))
                    || is_j || is_jal || is_jr || is_eret;
    assign redirect  = taken && !stall && !intr_take;

    assign imm_ext = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign npc_ext = npc_q + {{14{imm[15]}}, imm, 2'b00};
    assign connect = {npc_q[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        mux_pc = PcSeq;
        if (intr_take) begin
            mux_pc = PcIntr;
        end else if (redirect) begin
            if (is_beq || is_bne) begin
                mux_pc = PcBranch;
            end else if (is_jr) begin
                mux_pc = PcJr;
            end else if (is_eret) begin
                mux_pc = PcEret;
            end else begin
                mux_pc = PcJump;
            end
        end
    end

    always_comb begin
        if (rst) begin
            if_cond = CondZero;
        end else if (stall) begin
            if_cond = CondStall;
        end else begin
            if_cond = CondFlow;
        end
    end

    assign id_ir    = ir_q;
    assign id_pc    = pc_q;
    assign id_valid = full && !stall && !intr_take;
    assign epc_we   = intr_take;
    assign epc_out  = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we && (wb_addr != 5'd0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSquash;
            ir_q    <= IR_NON;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + 32'd4;
        end else if (intr_take || redirect) begin
            state_q <= StSquash;
            ir_q    <= IR_NON;
        end else if (stall) begin
            state_q <= StStall;
        end else begin
            state_q <= StRun;
            ir_q    <= if_ir;
            pc_q    <= if_pc;
            npc_q   <= if_npc;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed and random bench for instr_decode_stage against a behavioural ID-stage model.
module tb_instr_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] IR_NON   = 32'h0000_0000;

    localparam int KOther = 0;
    localparam int KBeq   = 1;
    localparam int KBne   = 2;
    localparam int KJ     = 3;
    localparam int KJal   = 4;
    localparam int KJr    = 5;
    localparam int KEret  = 6;

    localparam int ActLoad = 0;
    localparam int ActHold = 1;
    localparam int ActKill = 2;

    logic        clk, rst;
    logic [31:0] if_ir, if_pc, if_npc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_reg_write, ex_mem_read;
    logic [4:0]  ex_wa;
    logic        mem_reg_write;
    logic [4:0]  mem_wa;
    logic        intr_req;
    logic [31:0] id_ir, id_pc;
    logic        id_valid;
    logic [31:0] rs_val, rt_val, imm_ext, npc_ext, connect;
    logic [2:0]  mux_pc;
    logic [1:0]  if_cond;
    logic [31:0] epc_out;
    logic        epc_we;

    instr_decode_stage #(
        .RESET_PC (RESET_PC),
        .IR_NON   (IR_NON)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_ir         (if_ir),
        .if_pc         (if_pc),
        .if_npc        (if_npc),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_wa         (ex_wa),
        .mem_reg_write (mem_reg_write),
        .mem_wa        (mem_wa),
        .intr_req      (intr_req),
        .id_ir         (id_ir),
        .id_pc         (id_pc),
        .id_valid      (id_valid),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .imm_ext       (imm_ext),
        .npc_ext       (npc_ext),
        .connect       (connect),
        .mux_pc        (mux_pc),
        .if_cond       (if_cond),
        .epc_out       (epc_out),
        .epc_we        (epc_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model of the architectural ID contents
    logic [31:0] m_regs [32];
    logic        m_bubble;
    logic [31:0] m_ir, m_pc, m_npc;

    logic [31:0] e_rs, e_rt, e_imm, e_npc_ext, e_connect;
    logic [2:0]  e_mux;
    logic [1:0]  e_cond;
    logic        e_valid, e_epc_we;
    int          e_act;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_we && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_bubble = 1'b1;
        m_ir     = IR_NON;
        m_pc     = RESET_PC;
        m_npc    = RESET_PC + 32'd4;
    endtask

    task automatic model_eval();
        logic [5:0] op;
        logic [4:0] rs, rt;
        int         kind;
        int         srcs[$];
        int         bsrcs[$];
        bit         hz, tk;
        op = m_ir[31:26];
        rs = m_ir[25:21];
        rt = m_ir[20:16];
        if (m_ir == 32'h4200_0018) kind = KEret;
        else if (op == 6'h04) kind = KBeq;
        else if (op == 6'h05) kind = KBne;
        else if (op == 6'h02) kind = KJ;
        else if (op == 6'h03) kind = KJal;
        else if (op == 6'h00 && m_ir[5:0] == 6'h08) kind = KJr;
        else kind = KOther;

        e_rs      = reg_read(rs);
        e_rt      = reg_read(rt);
        e_imm     = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, m_ir[15:0]}
                                                      : 32'($signed(m_ir[15:0]));
        e_npc_ext = m_npc + 32'(int'($signed(m_ir[15:0])) * 4);
        e_connect = (m_npc & 32'hF000_0000) | (32'(m_ir[25:0]) << 2);

        if (!(op inside {6'h02, 6'h03, 6'h0F, 6'h10})) srcs.push_back(int'(rs));
        if (op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B}) srcs.push_back(int'(rt));
        if (kind == KBeq || kind == KBne || kind == KJr) bsrcs.push_back(int'(rs));
        if (kind == KBeq || kind == KBne) bsrcs.push_back(int'(rt));
        hz = 0;
        foreach (srcs[i]) if (ex_mem_read && ex_wa != 0 && srcs[i] == int'(ex_wa)) hz = 1;
        foreach (bsrcs[i]) begin
            if (ex_reg_write && ex_wa != 0 && bsrcs[i] == int'(ex_wa)) hz = 1;
            if (mem_reg_write && mem_wa != 0 && bsrcs[i] == int'(mem_wa)) hz = 1;
        end
        tk = (kind == KBeq && e_rs == e_rt) || (kind == KBne && e_rs != e_rt)
          || kind == KJ || kind == KJal || kind == KJr || kind == KEret;

        e_mux = 3'd5; e_cond = 2'b00; e_valid = 1'b0; e_epc_we = 1'b0; e_act = ActLoad;
        if (m_bubble) begin
            e_act = ActLoad;
        end else if (intr_req) begin
            e_mux = 3'd2; e_epc_we = 1'b1; e_act = ActKill;
        end else if (hz) begin
            e_cond = 2'b01; e_act = ActHold;
        end else if (tk) begin
            e_valid = 1'b1; e_act = ActKill;
            case (kind)
                KBeq, KBne: e_mux = 3'd0;
                KJr:        e_mux = 3'd1;
                KEret:      e_mux = 3'd3;
                default:    e_mux = 3'd4;
            endcase
        end else begin
            e_valid = 1'b1;
        end
        if (rst) e_cond = 2'b10;
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (e_act == ActLoad) begin
                m_bubble = 1'b0; m_ir = if_ir; m_pc = if_pc; m_npc = if_npc;
            end else if (e_act == ActKill) begin
                m_bubble = 1'b1; m_ir = IR_NON;
            end
        end
    endtask

    task automatic check_all();
        model_eval();
        chk("id_ir", id_ir, m_ir);
        chk("id_pc", id_pc, m_pc);
        chk("id_valid", 32'(id_valid), 32'(e_valid));
        chk("rs_val", rs_val, e_rs);
        chk("rt_val", rt_val, e_rt);
        chk("imm_ext", imm_ext, e_imm);
        chk("npc_ext", npc_ext, e_npc_ext);
        chk("connect", connect, e_connect);
        chk("mux_pc", 32'(mux_pc), 32'(e_mux));
        chk("if_cond", 32'(if_cond), 32'(e_cond));
        chk("epc_we", 32'(epc_we), 32'(e_epc_we));
        chk("epc_out", epc_out, m_pc);
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input logic [31:0] pc);
        if_ir  = ir;
        if_pc  = pc;
        if_npc = pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] idx;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        idx = 26'($urandom);
        case ($urandom_range(0, 13))
            0:  return {6'h09, rs, rt, imm};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            2:  return {6'h23, rs, rt, imm};
            3:  return {6'h2B, rs, rt, imm};
            4:  return {6'h0C, rs, rt, imm};
            5:  return {6'h0D, rs, rt, imm};
            6:  return {6'h04, rs, rt, imm};
            7:  return {6'h05, rs, rt, imm};
            8:  return {6'h02, idx};
            9:  return {6'h03, idx};
            10: return {6'h00, rs, 15'd0, 6'h08};
            11: return 32'h4200_0018;
            12: return {6'h0F, 5'd0, rt, imm};
            default: return {6'h0E, rs, rt, imm};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        fetch(32'h0, 32'h0);
        wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_wa = 0;
        mem_reg_write = 0; mem_wa = 0; intr_req = 0;
        #1;
        model_reset();
        settle();
        chk("rst_if_cond_zero", 32'(if_cond), 32'h2);
        chk("rst_id_pc", id_pc, 32'h0040_0000);
        chk("rst_mux_pc", 32'(mux_pc), 32'd5);
        advance();
        advance();
        rst = 1'b0;

        // T1: first real instruction issues the cycle after capture
        fetch(32'h2401_0005, 32'h0040_0000); settle(); advance();
        fetch(32'h0060_2820, 32'h0040_0004); settle();
        chk("t1_valid", 32'(id_valid), 32'h1);
        chk("t1_imm", imm_ext, 32'h5);
        chk("t1_mux", 32'(mux_pc), 32'd5);
        advance();

        // T2: WB bypass, then $0 stays zero
        fetch(32'h0000_3820, 32'h0040_0008);
        wb_we = 1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        settle();
        chk("t2_bypass", rs_val, 32'hDEAD_BEEF);
        advance();
        fetch(32'h0041_2020, 32'h0040_000C);
        wb_addr = 5'd0; wb_data = 32'h1234_5678;
        settle();
        chk("t2_r0", rs_val, 32'h0);
        advance();
        wb_we = 0;

        // T3: load-use stall, then release
        fetch(32'h1021_0003, 32'h0040_0010);
        ex_mem_read = 1; ex_reg_write = 1; ex_wa = 5'd2;
        settle();
        chk("t3_stall", 32'(if_cond), 32'h1);
        chk("t3_bubble", 32'(id_valid), 32'h0);
        advance();
        ex_mem_read = 0; ex_reg_write = 0; ex_wa = 0;
        settle();
        chk("t3_flow", 32'(if_cond), 32'h0);
        chk("t3_issue", 32'(id_valid), 32'h1);
        advance();

        // T4: beq taken squashes, bne equal falls through
        fetch(32'h2402_0007, 32'h0040_0014); settle();
        chk("t4_target", npc_ext, 32'h0040_0020);
        chk("t4_mux", 32'(mux_pc), 32'd0);
        advance();
        fetch(32'h1421_0003, 32'h0040_0020); settle();
        chk("t4_squash", id_ir, 32'h0);
        advance();
        fetch(32'h0810_0004, 32'h0040_0004); settle();
        chk("t4_bne_seq", 32'(mux_pc), 32'd5);
        advance();

        // T5: jump target, jr operand hazard from MEM
        fetch(32'h2403_0001, 32'h0040_0008); settle();
        chk("t5_connect", connect, 32'h0040_0010);
        chk("t5_mux", 32'(mux_pc), 32'd4);
        advance();
        fetch(32'h03E0_0008, 32'h0040_0010); settle(); advance();
        fetch(32'h2404_0002, 32'h0040_0014);
        mem_reg_write = 1; mem_wa = 5'd31;
        settle();
        chk("t5_jr_stall", 32'(if_cond), 32'h1);
        advance();
        mem_reg_write = 0; mem_wa = 0;
        settle();
        chk("t5_jr_mux", 32'(mux_pc), 32'd1);
        advance();

        // T6: interrupt wins over a coincident load-use hazard
        fetch(32'h0041_2020, 32'h0040_0040); settle(); advance();
        fetch(32'h2405_0003, 32'h0040_0044);
        ex_mem_read = 1; ex_wa = 5'd2; intr_req = 1;
        settle();
        chk("t6_mux", 32'(mux_pc), 32'd2);
        chk("t6_epc_we", 32'(epc_we), 32'h1);
        chk("t6_epc", epc_out, 32'h0040_0040);
        chk("t6_kill", 32'(id_valid), 32'h0);
        advance();
        ex_mem_read = 0; ex_wa = 0; intr_req = 0;
        settle();
        chk("t6_squash", id_ir, 32'h0);
        advance();

        // Random traffic, including wrap-around PCs
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            fetch(rand_instr(), pc);
            wb_we         = 1'($urandom_range(0, 1));
            wb_addr       = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            ex_reg_write  = ($urandom_range(0, 3) == 0);
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            ex_wa         = 5'($urandom_range(0, 7));
            mem_reg_write = ($urandom_range(0, 3) == 0);
            mem_wa        = 5'($urandom_range(0, 7));
            intr_req      = ($urandom_range(0, 19) == 0);
            settle();
            advance();
        end

        // Reset asserted in the middle of a stall
        wb_we = 0; ex_reg_write = 0; ex_mem_read = 0; ex_wa = 0;
        mem_reg_write = 0; mem_wa = 0; intr_req = 0;
        fetch(32'h0041_2020, 32'h0040_0080);
        settle(); advance();
        settle(); advance();
        ex_mem_read = 1; ex_wa = 5'd2;
        settle();
        chk("mid_stall", 32'(if_cond), 32'h1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("mid_rst_cond", 32'(if_cond), 32'h2);
        chk("mid_rst_pc", id_pc, 32'h0040_0000);
        advance();
        rst = 1'b0;
        ex_mem_read = 0; ex_wa = 0;
        settle();
        advance();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
